// File: rtl/hvac_if.sv
// Request/actuator bundle between the air-conditioning monitor and the actuator sequencer.
interface hvac_if;
    logic       heating;
    logic       cooling;
    logic       fan;
    logic       heater_en;
    logic       compressor_en;
    logic       fault;
    logic [2:0] state;

    modport master (
        output heating,
        output cooling,
        input  fan,
        input  heater_en,
        input  compressor_en,
        input  fault,
        input  state
    );

    modport slave (
        input  heating,
        input  cooling,
        output fan,
        output heater_en,
        output compressor_en,
        output fault,
        output state
    );
endinterface

// File: rtl/hvac_sequencer.sv
// Actuator sequencer: fan pre/post purge, minimum heater/compressor on-time and
// compressor restart lockout, driven by the monitor's heating/cooling requests.
module hvac_sequencer #(
    parameter int unsigned PRE_CYCLES     = 4,
    parameter int unsigned POST_CYCLES    = 8,
    parameter int unsigned MIN_ON         = 16,
    parameter int unsigned LOCKOUT_CYCLES = 32
) (
    input logic  clk,
    input logic  rst_n,
    hvac_if.slave bus
);

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StPre     = 3'd1,
        StHeat    = 3'd2,
        StCool    = 3'd3,
        StPost    = 3'd4,
        StLockout = 3'd5
    } state_e;

    typedef enum logic {
        ModeHeat = 1'b0,
        ModeCool = 1'b1
    } mode_e;

    localparam logic [7:0] PreLast     = 8'(PRE_CYCLES - 1);
    localparam logic [7:0] PostLast    = 8'(POST_CYCLES - 1);
    localparam logic [7:0] MinOnLast   = 8'(MIN_ON - 1);
    localparam logic [7:0] LockoutLast = 8'(LOCKOUT_CYCLES - 1);

    // Plain vector register so illegal codes are representable and recoverable.
    logic [2:0] state_q;
    state_e     state_d;
    logic [7:0] cnt_q, cnt_d;
    mode_e      mode_q, mode_d;
    logic       fan_q, fan_d;
    logic       heater_q, heater_d;
    logic       comp_q, comp_d;
    logic       fault_q;

    logic heat_req, cool_req, mode_req;

    always_comb begin
        heat_req = bus.heating & ~bus.cooling;
        cool_req = bus.cooling & ~bus.heating;
        mode_req = (mode_q == ModeHeat) ? heat_req : cool_req;

        // Any transition clears the counter; only staying in a state advances it.
        state_d = StIdle;
        cnt_d   = 8'd0;
        mode_d  = mode_q;

        case (state_q)
            StIdle: begin
                if (heat_req) begin
                    state_d = StPre;
                    mode_d  = ModeHeat;
                end else if (cool_req) begin
                    state_d = StPre;
                    mode_d  = ModeCool;
                end
            end
            StPre: begin
                if (!mode_req) begin
                    state_d = StPost;
                end else if (cnt_q == PreLast) begin
                    state_d = (mode_q == ModeHeat) ? StHeat : StCool;
                end else begin
                    state_d = StPre;
                    cnt_d   = cnt_q + 8'd1;
                end
            end
            StHeat: begin
                if (cnt_q == MinOnLast && !heat_req) begin
                    state_d = StPost;
                end else begin
                    state_d = StHeat;
                    cnt_d   = (cnt_q == MinOnLast) ? cnt_q : cnt_q + 8'd1;
                end
            end
            StCool: begin
                if (cnt_q == MinOnLast && !cool_req) begin
                    state_d = StPost;
                end else begin
                    state_d = StCool;
                    cnt_d   = (cnt_q == MinOnLast) ? cnt_q : cnt_q + 8'd1;
                end
            end
            StPost: begin
                if (cnt_q == PostLast) begin
                    state_d = (mode_q == ModeCool) ? StLockout : StIdle;
                end else begin
                    state_d = StPost;
                    cnt_d   = cnt_q + 8'd1;
                end
            end
            StLockout: begin
                if (cnt_q != LockoutLast) begin
                    state_d = StLockout;
                    cnt_d   = cnt_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Outputs are decoded from the next state so they move with the state register.
        fan_d    = (state_d == StPre) || (state_d == StHeat) ||
                   (state_d == StCool) || (state_d == StPost);
        heater_d = (state_d == StHeat);
        comp_d   = (state_d == StCool);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= 8'd0;
            mode_q   <= ModeHeat;
            fan_q    <= 1'b0;
            heater_q <= 1'b0;
            comp_q   <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mode_q   <= mode_d;
            fan_q    <= fan_d;
            heater_q <= heater_d;
            comp_q   <= comp_d;
            fault_q  <= bus.heating & bus.cooling;
        end
    end

    assign bus.fan           = fan_q;
    assign bus.heater_en     = heater_q;
    assign bus.compressor_en = comp_q;
    assign bus.fault         = fault_q;
    assign bus.state         = state_q;

endmodule

// File: tb/tb_hvac_sequencer.sv
// Directed bench for hvac_sequencer with default timing parameters.
module tb_hvac_sequencer;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    hvac_if ifc ();

    hvac_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h required=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [2:0] st, input logic f,
                           input logic h, input logic c, input logic flt);
        chk({tag, ".state"}, {5'd0, ifc.state}, {5'd0, st});
        chk({tag, ".fan"}, {7'd0, ifc.fan}, {7'd0, f});
        chk({tag, ".heater_en"}, {7'd0, ifc.heater_en}, {7'd0, h});
        chk({tag, ".compressor_en"}, {7'd0, ifc.compressor_en}, {7'd0, c});
        chk({tag, ".fault"}, {7'd0, ifc.fault}, {7'd0, flt});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        rst_n       = 1'b0;
        ifc.heating = 1'b0;
        ifc.cooling = 1'b0;
        #13;
        chk_all("reset", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk_all("idle", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Long heating request: 40 sampled edges, then drop.
        ifc.heating = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            chk_all("heat_run", (i < 4) ? 3'd1 : 3'd2, 1'b1, (i >= 4), 1'b0, 1'b0);
        end
        ifc.heating = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk_all("heat_post", 3'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        tick();
        chk_all("heat_done", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Short heating request aborts the pre-purge.
        ifc.heating = 1'b1;
        tick();
        chk_all("abort_pre0", 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        chk_all("abort_pre1", 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        ifc.heating = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk_all("abort_post", 3'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        tick();
        chk_all("abort_done", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Short cooling request: minimum on-time, post-purge, lockout.
        ifc.cooling = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_all("cool_pre", 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        tick();
        chk_all("cool_entry", 3'd3, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 1; i < 16; i++) begin
            tick();
            chk_all("cool_minon", 3'd3, 1'b1, 1'b0, 1'b1, 1'b0);
            if (i == 3) ifc.cooling = 1'b0;
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            chk_all("cool_post", 3'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        tick();
        chk_all("lockout_entry", 3'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        ifc.cooling = 1'b1;
        for (int i = 1; i < 32; i++) begin
            tick();
            chk_all("lockout_hold", 3'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        tick();
        chk_all("lockout_idle", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk_all("relaunch_pre", 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_all("relaunch_pre_hold", 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        tick();
        chk_all("relaunch_cool", 3'd3, 1'b1, 1'b0, 1'b1, 1'b0);

        // Reset mid-cooling: immediate shutdown, no lockout afterwards.
        tick();
        rst_n = 1'b0;
        #1;
        chk_all("rst_mid_cool", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk_all("post_rst_pre", 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_all("post_rst_pre_hold", 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        tick();
        chk_all("post_rst_cool", 3'd3, 1'b1, 1'b0, 1'b1, 1'b0);
        rst_n       = 1'b0;
        ifc.cooling = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Both requests high in IDLE: fault only, no start.
        ifc.heating = 1'b1;
        ifc.cooling = 1'b1;
        tick();
        chk_all("both_idle", 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        ifc.heating = 1'b0;
        ifc.cooling = 1'b0;
        tick();
        chk_all("both_clear", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Both requests high during HEAT: minimum on-time then post-purge.
        ifc.heating = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_all("both_pre", 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        tick();
        chk_all("both_heat_entry", 3'd2, 1'b1, 1'b1, 1'b0, 1'b0);
        ifc.cooling = 1'b1;
        for (int i = 1; i < 16; i++) begin
            tick();
            chk_all("both_heat_minon", 3'd2, 1'b1, 1'b1, 1'b0, 1'b1);
        end
        tick();
        chk_all("both_heat_exit", 3'd4, 1'b1, 1'b0, 1'b0, 1'b1);
        ifc.heating = 1'b0;
        ifc.cooling = 1'b0;
        for (int i = 1; i < 8; i++) begin
            tick();
            chk_all("both_post", 3'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        tick();
        chk_all("both_done", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Illegal state code recovers to IDLE.
        force dut.state_q = 3'd6;
        #1;
        release dut.state_q;
        tick();
        chk_all("illegal_state", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
